// File: rtl/uart_cmd_initiator_pkg.sv
// uart_cmd_initiator_pkg
// Shared protocol constants for the flash-image command link: frame and
// command bytes, ack bytes, VERSION response length, status codes, the
// initiator state encoding and the header-byte selector.
// Ports: none (package).
package uart_cmd_initiator_pkg;

  // Frame start and command bytes
  localparam logic [7:0] CMD_HDR     = 8'h21;  // '!'
  localparam logic [7:0] CMD_RD      = 8'h52;  // 'R'
  localparam logic [7:0] CMD_WR      = 8'h57;  // 'W'
  localparam logic [7:0] CMD_VERSION = 8'h56;  // 'V'

  // Ack bytes returned by the responder
  localparam logic [7:0] ACK_WR      = 8'h57;  // 'W' after a write payload
  localparam logic [7:0] ACK_UNKNOWN = 8'h3F;  // '?' for an unknown command

  // Number of bytes in the VERSION response
  localparam logic [23:0] VERSION_LEN = 24'd8;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'd0,
    STATUS_ECHO_ERR = 2'd1,
    STATUS_TIMEOUT  = 2'd2,
    STATUS_ACK_ERR  = 2'd3
  } status_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_CMD,
    ST_ECHO,
    ST_LEN,
    ST_ADDR,
    ST_DATA,
    ST_ACK,
    ST_RECV,
    ST_FIN
  } state_t;

  // Header field bytes in wire order: L2 L1 L0 A3 A2 A1 A0 (big-endian).
  function automatic logic [7:0] hdr_byte(input logic [23:0] len,
                                          input logic [31:0] addr,
                                          input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = len[23:16];
      3'd1:    b = len[15:8];
      3'd2:    b = len[7:0];
      3'd3:    b = addr[31:24];
      3'd4:    b = addr[23:16];
      3'd5:    b = addr[15:8];
      3'd6:    b = addr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_initiator_if.sv
// uart_cmd_initiator_if
// Bundles the request, payload, read-data, UART byte and completion signals
// of the command initiator.
//   master : the initiator itself (drives ready/strobe/status outputs)
//   slave  : the surrounding logic and UART pair
interface uart_cmd_initiator_if;

  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [23:0] req_len;
  logic [31:0] req_addr;

  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;

  logic [7:0]  rd_data;
  logic        rd_valid;

  logic [7:0]  uart_txd;
  logic        uart_txd_strobe;
  logic        uart_txd_ready;
  logic [7:0]  uart_rxd;
  logic        uart_rxd_strobe;

  logic        busy;
  logic        done;
  logic [1:0]  status;

  modport master (
    input  req_valid, req_cmd, req_len, req_addr,
    input  wr_data, wr_valid,
    input  uart_txd_ready, uart_rxd, uart_rxd_strobe,
    output req_ready, wr_ready, rd_data, rd_valid,
    output uart_txd, uart_txd_strobe,
    output busy, done, status
  );

  modport slave (
    output req_valid, req_cmd, req_len, req_addr,
    output wr_data, wr_valid,
    output uart_txd_ready, uart_rxd, uart_rxd_strobe,
    input  req_ready, wr_ready, rd_data, rd_valid,
    input  uart_txd, uart_txd_strobe,
    input  busy, done, status
  );

endinterface

// File: rtl/uart_cmd_initiator.sv
// uart_cmd_initiator
// Host-side initiator for the serial flash-image command protocol. Takes one
// request at a time, sends '!' + command, checks the echo, sends the 3-byte
// length and 4-byte address for R/W, then streams write payload out or read
// data in, and finishes with a one-cycle done pulse plus a status code.
// Ports:
//   clk    system clock, everything on posedge
//   reset  asynchronous, active-high
//   bus    uart_cmd_initiator_if.master: request, payload, read data,
//          UART byte interface, busy/done/status
// Parameter:
//   TIMEOUT  idle cycles allowed while waiting for any response byte
module uart_cmd_initiator
  import uart_cmd_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input logic                  clk,
  input logic                  reset,
  uart_cmd_initiator_if.master bus
);

  localparam logic [31:0] TIMER_LAST = TIMEOUT - 32'd1;

  state_t      state;
  logic [7:0]  cmd_q;
  logic [23:0] len_q;
  logic [31:0] addr_q;
  logic [2:0]  field_idx;
  logic [23:0] count;
  logic [31:0] timer;
  status_t     result;

  logic send_ok;
  logic waiting;
  logic timed_out;

  // A byte may be strobed only when the transmitter is idle and no strobe
  // was issued last cycle, so strobes are never back to back.
  assign send_ok   = bus.uart_txd_ready && !bus.uart_txd_strobe;
  assign waiting   = (state == ST_ECHO) || (state == ST_ACK) || (state == ST_RECV);
  assign timed_out = (timer == TIMER_LAST);

  // Payload is accepted combinationally so it is strobed in the same cycle.
  assign bus.wr_ready = (state == ST_DATA) && send_ok && (count != 24'd0);

  // Single FSM with registered outputs. The timeout counter only advances
  // in the waiting states and is cleared by any rx strobe or by being in a
  // non-waiting state, which also clears it on entry to a waiting state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= ST_IDLE;
      cmd_q               <= '0;
      len_q               <= '0;
      addr_q              <= '0;
      field_idx           <= '0;
      count               <= '0;
      timer               <= '0;
      result              <= STATUS_OK;
      bus.req_ready       <= 1'b0;
      bus.rd_data         <= '0;
      bus.rd_valid        <= 1'b0;
      bus.uart_txd        <= '0;
      bus.uart_txd_strobe <= 1'b0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.status          <= '0;
    end else begin
      bus.uart_txd_strobe <= 1'b0;
      bus.rd_valid        <= 1'b0;
      bus.done            <= 1'b0;

      if (waiting && !bus.uart_rxd_strobe) begin
        timer <= timer + 32'd1;
      end else begin
        timer <= '0;
      end

      case (state)
        ST_IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            cmd_q         <= bus.req_cmd;
            len_q         <= bus.req_len;
            addr_q        <= bus.req_addr;
            result        <= STATUS_OK;
            bus.busy      <= 1'b1;
            bus.req_ready <= 1'b0;
            state         <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (send_ok) begin
            bus.uart_txd        <= CMD_HDR;
            bus.uart_txd_strobe <= 1'b1;
            state               <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (send_ok) begin
            bus.uart_txd        <= cmd_q;
            bus.uart_txd_strobe <= 1'b1;
            state               <= ST_ECHO;
          end
        end

        ST_ECHO: begin
          if (bus.uart_rxd_strobe) begin
            if (bus.uart_rxd != cmd_q) begin
              result <= STATUS_ECHO_ERR;
              state  <= ST_FIN;
            end else if ((cmd_q == CMD_RD) || (cmd_q == CMD_WR)) begin
              field_idx <= 3'd0;
              state     <= ST_LEN;
            end else if (cmd_q == CMD_VERSION) begin
              count <= VERSION_LEN;
              state <= ST_RECV;
            end else begin
              state <= ST_ACK;
            end
          end else if (timed_out) begin
            result <= STATUS_TIMEOUT;
            state  <= ST_FIN;
          end
        end

        // field_idx runs 0..6 across LEN and ADDR to pick the header byte.
        ST_LEN: begin
          if (send_ok) begin
            bus.uart_txd        <= hdr_byte(len_q, addr_q, field_idx);
            bus.uart_txd_strobe <= 1'b1;
            field_idx           <= field_idx + 3'd1;
            if (field_idx == 3'd2) begin
              state <= ST_ADDR;
            end
          end
        end

        // The branch is taken the cycle after A0 goes out (field_idx == 7).
        ST_ADDR: begin
          if (field_idx == 3'd7) begin
            count <= len_q;
            if (cmd_q == CMD_RD) begin
              state <= (len_q == 24'd0) ? ST_FIN : ST_RECV;
            end else begin
              state <= ST_DATA;
            end
          end else if (send_ok) begin
            bus.uart_txd        <= hdr_byte(len_q, addr_q, field_idx);
            bus.uart_txd_strobe <= 1'b1;
            field_idx           <= field_idx + 3'd1;
          end
        end

        // A stalled payload source is waited on indefinitely.
        ST_DATA: begin
          if (count == 24'd0) begin
            state <= ST_ACK;
          end else if (bus.wr_valid && bus.wr_ready) begin
            bus.uart_txd        <= bus.wr_data;
            bus.uart_txd_strobe <= 1'b1;
            count               <= count - 24'd1;
          end
        end

        // Only a write can succeed here; '?' for other commands still
        // reports an ack error.
        ST_ACK: begin
          if (bus.uart_rxd_strobe) begin
            if ((cmd_q == CMD_WR) && (bus.uart_rxd == ACK_WR)) begin
              result <= STATUS_OK;
            end else begin
              result <= STATUS_ACK_ERR;
            end
            state <= ST_FIN;
          end else if (timed_out) begin
            result <= STATUS_TIMEOUT;
            state  <= ST_FIN;
          end
        end

        ST_RECV: begin
          if (bus.uart_rxd_strobe) begin
            bus.rd_data  <= bus.uart_rxd;
            bus.rd_valid <= 1'b1;
            count        <= count - 24'd1;
            if (count == 24'd1) begin
              state <= ST_FIN;
            end
          end else if (timed_out) begin
            result <= STATUS_TIMEOUT;
            state  <= ST_FIN;
          end
        end

        ST_FIN: begin
          bus.done   <= 1'b1;
          bus.status <= result;
          bus.busy   <= 1'b0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
